// File: rtl/geogenius_pkg.sv
// Shared types and constants for the geogenius sequence engine.
package geogenius_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    GERA        = 4'd2,
    MOSTRA      = 4'd3,
    INTERVALO   = 4'd4,
    ESPERA      = 4'd5,
    COMPARA     = 4'd6,
    PROXIMA     = 4'd7,
    FIM_ACERTO  = 4'd8,
    FIM_ERRO    = 4'd9,
    FIM_TIMEOUT = 4'd10
  } estado_t;

  // Feedback taps b15, b13, b12, b10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/geogenius_lfsr16.sv
// 16-bit Fibonacci LFSR; seed load with zero substitution, one-step advance.
// novo_item is the item the next advance will produce, so it can be stored on the same edge.
module geogenius_lfsr16
  import geogenius_pkg::*;
#(
  parameter int IDX_W = 3
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [15:0]      seed,
  output logic [IDX_W-1:0] novo_item
);

  logic [15:0] value;
  logic [15:0] next_value;

  assign next_value = {value[14:0], ^(value & LFSR_TAPS)};
  assign novo_item  = next_value[IDX_W-1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      value <= LFSR_SEED;
    end else if (load) begin
      value <= (seed == 16'h0000) ? LFSR_SEED : seed;
    end else if (advance) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/geogenius_seq_engine.sv
// Simon-style sequence engine: grows a random sequence, replays it, checks the player's presses.
// Press seen one cycle after its edge, verdict the cycle after; no backpressure, buttons must be released between presses.
module geogenius_seq_engine
  import geogenius_pkg::*;
#(
  parameter int N_BOTOES        = 8,
  parameter int DEPTH           = 16,
  parameter int MOSTRA_CICLOS   = 1000,
  parameter int TIMEOUT_NORMAL  = 5000,
  parameter int TIMEOUT_DIFICIL = 2500,
  parameter int PRESCALE        = 1000,
  localparam int IDX_W          = $clog2(N_BOTOES),
  localparam int SCORE_W        = $clog2(DEPTH + 1)
)(
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                dificuldade,
  input  logic                modo,
  input  logic [15:0]         semente,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [SCORE_W-1:0]  score,
  output logic [15:0]         tempo_de_jogo,
  output logic [3:0]          db_estado
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TMAX   = (TIMEOUT_NORMAL > TIMEOUT_DIFICIL) ? TIMEOUT_NORMAL : TIMEOUT_DIFICIL;
  localparam int TOUT_W = $clog2(TMAX + 1);
  localparam int CNT_W  = $clog2(MOSTRA_CICLOS + 1);
  localparam int PRE_W  = $clog2(PRESCALE + 1);

  estado_t             estado, estado_n;
  logic [SCORE_W-1:0]  rodada, rodada_n;
  logic [SCORE_W-1:0]  idx, idx_n;
  logic [SCORE_W-1:0]  score_r, score_n;
  logic [SCORE_W-1:0]  ultimo;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [TOUT_W-1:0]   tout, tout_n, tout_inc, limite;
  logic [N_BOTOES-1:0] jogada, jogada_n;
  logic [N_BOTOES-1:0] alvo;
  logic                modo_r, modo_n, dif_r, dif_n;
  logic                lfsr_load, lfsr_adv, mem_we;
  logic [IDX_W-1:0]    novo_item;
  logic [IDX_W-1:0]    mem [DEPTH];
  logic                btn_prev, press, conta;
  logic [PRE_W-1:0]    presc;
  logic [15:0]         tempo;

  geogenius_lfsr16 #(.IDX_W(IDX_W)) u_lfsr (
    .clock     (clock),
    .reset     (reset),
    .load      (lfsr_load),
    .advance   (lfsr_adv),
    .seed      (semente),
    .novo_item (novo_item)
  );

  assign ultimo   = rodada - SCORE_W'(1);
  assign alvo     = N_BOTOES'(1) << mem[idx[ADDR_W-1:0]];
  assign press    = (|botoes) && !btn_prev;
  assign tout_inc = tout + TOUT_W'(1);
  assign limite   = dif_r ? TOUT_W'(TIMEOUT_DIFICIL) : TOUT_W'(TIMEOUT_NORMAL);
  assign conta    = estado inside {GERA, MOSTRA, INTERVALO, ESPERA, COMPARA, PROXIMA};

  always_comb begin
    estado_n  = estado;
    rodada_n  = rodada;
    idx_n     = idx;
    score_n   = score_r;
    cnt_n     = cnt;
    tout_n    = tout;
    jogada_n  = jogada;
    modo_n    = modo_r;
    dif_n     = dif_r;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    mem_we    = 1'b0;
    case (estado)
      INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (jogar) begin
          estado_n  = PREPARA;
          lfsr_load = 1'b1;
          modo_n    = modo;
          dif_n     = dificuldade;
        end
      end
      PREPARA: begin
        rodada_n = '0;
        score_n  = '0;
        idx_n    = '0;
        cnt_n    = '0;
        estado_n = GERA;
      end
      GERA: begin
        // Old rodada is both the write address and the newest item's index
        rodada_n = rodada + SCORE_W'(1);
        lfsr_adv = 1'b1;
        mem_we   = 1'b1;
        idx_n    = modo_r ? rodada : '0;
        cnt_n    = '0;
        estado_n = MOSTRA;
      end
      MOSTRA: begin
        if (cnt == CNT_W'(MOSTRA_CICLOS - 1)) begin
          cnt_n    = '0;
          estado_n = INTERVALO;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      INTERVALO: begin
        if (cnt == CNT_W'(MOSTRA_CICLOS - 1)) begin
          cnt_n = '0;
          if (idx < ultimo) begin
            idx_n    = idx + SCORE_W'(1);
            estado_n = MOSTRA;
          end else begin
            idx_n    = '0;
            tout_n   = '0;
            estado_n = ESPERA;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ESPERA: begin
        if (press) begin
          jogada_n = botoes;
          estado_n = COMPARA;
        end else if (tout_inc == limite) begin
          estado_n = FIM_TIMEOUT;
        end else begin
          tout_n = tout_inc;
        end
      end
      COMPARA: begin
        if (jogada != alvo) begin
          estado_n = FIM_ERRO;
        end else if (idx < ultimo) begin
          idx_n    = idx + SCORE_W'(1);
          tout_n   = '0;
          estado_n = ESPERA;
        end else begin
          estado_n = PROXIMA;
        end
      end
      PROXIMA: begin
        score_n = rodada;
        if (rodada == SCORE_W'(DEPTH)) begin
          estado_n = FIM_ACERTO;
        end else begin
          idx_n    = '0;
          estado_n = GERA;
        end
      end
      default: estado_n = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= INICIAL;
      rodada   <= '0;
      idx      <= '0;
      score_r  <= '0;
      cnt      <= '0;
      tout     <= '0;
      jogada   <= '0;
      modo_r   <= 1'b0;
      dif_r    <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      estado   <= estado_n;
      rodada   <= rodada_n;
      idx      <= idx_n;
      score_r  <= score_n;
      cnt      <= cnt_n;
      tout     <= tout_n;
      jogada   <= jogada_n;
      modo_r   <= modo_n;
      dif_r    <= dif_n;
      btn_prev <= |botoes;
    end
  end

  // Sequence storage is deliberately left out of reset
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[rodada[ADDR_W-1:0]] <= novo_item;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      presc <= '0;
      tempo <= '0;
    end else if (estado == PREPARA) begin
      presc <= '0;
      tempo <= '0;
    end else if (conta) begin
      if (presc == PRE_W'(PRESCALE - 1)) begin
        presc <= '0;
        if (tempo != 16'hFFFF) tempo <= tempo + 16'd1;
      end else begin
        presc <= presc + PRE_W'(1);
      end
    end
  end

  always_comb begin
    leds = '0;
    if (estado == MOSTRA) leds = alvo;
    else if (estado == ESPERA) leds = botoes;
  end

  assign pronto        = estado inside {FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT};
  assign acertou       = (estado == FIM_ACERTO);
  assign errou         = (estado == FIM_ERRO);
  assign timeout       = (estado == FIM_TIMEOUT);
  assign score         = score_r;
  assign tempo_de_jogo = tempo;
  assign db_estado     = estado;

endmodule

// File: tb/tb_geogenius_seq_engine.sv
// Bench for geogenius_seq_engine: randomized games, expectations queued by the stimulus and checked by a monitor.
module tb_geogenius_seq_engine;

  localparam int NB = 4;
  localparam int DP = 3;
  localparam int MC = 4;
  localparam int TN = 20;
  localparam int TD = 10;
  localparam int PS = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          jogar = 1'b0;
  logic          dificuldade = 1'b0;
  logic          modo = 1'b0;
  logic [15:0]   semente = 16'h0;
  logic [NB-1:0] botoes = '0;
  logic [NB-1:0] leds;
  logic          pronto, acertou, errou, timeout;
  logic [1:0]    score;
  logic [15:0]   tempo_de_jogo;
  logic [3:0]    db_estado;

  geogenius_seq_engine #(
    .N_BOTOES(NB), .DEPTH(DP), .MOSTRA_CICLOS(MC),
    .TIMEOUT_NORMAL(TN), .TIMEOUT_DIFICIL(TD), .PRESCALE(PS)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .dificuldade(dificuldade),
    .modo(modo), .semente(semente), .botoes(botoes), .leds(leds),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .score(score), .tempo_de_jogo(tempo_de_jogo), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int fim;
    int sc;
    int lim;
  } fim_t;

  fim_t exp_fim[$];
  int   exp_leds[$];
  int   seq[DP];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference sequence straight from the LFSR rules
  task automatic gen_seq(input logic [15:0] sd);
    logic [15:0] s;
    s = (sd == 16'h0) ? 16'hACE1 : sd;
    for (int k = 0; k < DP; k++) begin
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      seq[k] = int'(s[1:0]);
    end
  endtask

  task automatic wait_state(input int st, input int bound);
    int n;
    n = 0;
    while (int'(db_estado) != st && n < bound) begin
      tick();
      n++;
    end
    if (int'(db_estado) != st) begin
      checks++;
      $display("FAIL wait_state_%0d: timed out, state is %0d", st, db_estado);
    end
  endtask

  task automatic wait_pronto();
    int n;
    n = 0;
    while (!pronto && n < 500) begin
      tick();
      n++;
    end
    if (!pronto) begin
      checks++;
      $display("FAIL wait_pronto: game never ended, state is %0d", db_estado);
    end
    repeat (3) tick();
  endtask

  task automatic press(input logic [NB-1:0] v, input int h);
    botoes = v;
    repeat (h) tick();
    botoes = '0;
    tick();
  endtask

  // Monitor: checks each replayed LED and each end-of-game report against the queues
  int         cyc = 0;
  int         esp_in = 0;
  int         nconta = 0;
  logic [3:0] prev_st = 4'd0;
  logic       prev_pronto = 1'b0;

  always @(negedge clock) begin
    fim_t e;
    int   el;
    cyc++;
    if (!reset) begin
      prev_st     = 4'd0;
      prev_pronto = 1'b0;
      nconta      = 0;
    end else begin
      if (db_estado == 4'd1) nconta = 0;
      else if (db_estado >= 4'd2 && db_estado <= 4'd7) nconta++;
      if (db_estado == 4'd5 && prev_st != 4'd5) esp_in = cyc;
      if (db_estado == 4'd3 && prev_st != 4'd3) begin
        if (exp_leds.size() == 0) begin
          checks++;
          $display("FAIL replay_led: unexpected replay, got %b, expected none", leds);
        end else begin
          el = exp_leds.pop_front();
          check("replay_led", int'(leds), el);
        end
      end
      if (pronto && !prev_pronto) begin
        if (exp_fim.size() == 0) begin
          checks++;
          $display("FAIL end_report: unexpected end in state %0d, expected none", db_estado);
        end else begin
          e = exp_fim.pop_front();
          check("end_state", int'(db_estado), e.fim);
          check("end_score", int'(score), e.sc);
          check("end_acertou", int'(acertou), int'(e.fim == 8));
          check("end_errou", int'(errou), int'(e.fim == 9));
          check("end_timeout", int'(timeout), int'(e.fim == 10));
          check("end_tempo", int'(tempo_de_jogo), nconta / PS);
          if (e.fim == 10) check("timeout_latency", cyc - esp_in, e.lim);
        end
      end
      prev_st     = db_estado;
      prev_pronto = pronto;
    end
  end

  // One game: f_kind 0 wrong single, 1 two buttons, 2 no press
  task automatic run_game(input bit m, input bit d, input logic [15:0] sd,
                          input int f_round, input int f_item, input int f_kind,
                          input int rst_round, input bit jog_esp, input bit hold_thr);
    fim_t             e;
    int               shown, first, last, gap;
    logic [NB-1:0]    v;
    gen_seq(sd);
    shown = (rst_round > 0) ? rst_round : ((f_round > 0) ? f_round : DP);
    for (int r = 1; r <= shown; r++) begin
      first = m ? r - 1 : 0;
      last  = (rst_round > 0 && r == rst_round) ? first : r - 1;
      for (int j = first; j <= last; j++) exp_leds.push_back(1 << seq[j]);
    end
    if (rst_round == 0) begin
      e.lim = d ? TD : TN;
      if (f_round > 0) begin
        e.fim = (f_kind == 2) ? 10 : 9;
        e.sc  = f_round - 1;
      end else begin
        e.fim = 8;
        e.sc  = DP;
      end
      exp_fim.push_back(e);
    end

    modo = m;
    dificuldade = d;
    semente = sd;
    jogar = 1'b1;
    tick();
    jogar = 1'b0;

    for (int r = 1; r <= DP; r++) begin
      if (r == rst_round) begin
        wait_state(3, 300);
        tick();
        reset = 1'b0;
        tick();
        check("rst_state", int'(db_estado), 0);
        check("rst_leds", int'(leds), 0);
        check("rst_score", int'(score), 0);
        check("rst_tempo", int'(tempo_de_jogo), 0);
        check("rst_pronto", int'(pronto), 0);
        reset = 1'b1;
        tick();
        return;
      end
      for (int j = 0; j < r; j++) begin
        wait_state(5, 300);
        if (jog_esp && r == 1 && j == 0) begin
          jogar = 1'b1;
          tick();
          jogar = 1'b0;
          check("jogar_ignored", int'(db_estado), 5);
        end
        if (r == f_round && j == f_item) begin
          if (f_kind == 2) begin
            wait_pronto();
          end else begin
            v = NB'(1) << ((seq[j] + 1 + $urandom_range(0, 2)) % NB);
            if (f_kind == 1) v = v | (NB'(1) << seq[j]);
            press(v, 1);
            wait_pronto();
          end
          return;
        end
        gap = $urandom_range(0, 3);
        repeat (gap) tick();
        if (hold_thr && r == 2 && j == 0) begin
          botoes = NB'(1) << seq[j];
          repeat (8) tick();
          check("hold_no_repress", int'(db_estado), 5);
          botoes = '0;
          tick();
        end else begin
          press(NB'(1) << seq[j], $urandom_range(1, 3));
        end
      end
    end
    wait_pronto();
  endtask

  initial begin
    int fr, fi, fk;
    logic [15:0] sd;
    repeat (3) tick();
    check("reset_state", int'(db_estado), 0);
    check("reset_leds", int'(leds), 0);
    check("reset_pronto", int'(pronto), 0);
    check("reset_score", int'(score), 0);
    check("reset_tempo", int'(tempo_de_jogo), 0);
    check("reset_flags", int'({acertou, errou, timeout}), 0);
    reset = 1'b1;
    tick();

    run_game(1'b0, 1'b0, 16'h0001, 0, 0, 0, 0, 1'b0, 1'b0);
    run_game(1'b1, 1'b0, 16'h0001, 0, 0, 0, 0, 1'b0, 1'b0);
    run_game(1'b0, 1'b0, 16'h0001, 2, 0, 0, 0, 1'b0, 1'b0);
    run_game(1'b0, 1'b1, 16'h0001, 1, 0, 2, 0, 1'b0, 1'b0);
    run_game(1'b0, 1'b0, 16'h0001, 1, 0, 2, 0, 1'b0, 1'b0);
    run_game(1'b0, 1'b0, 16'h0001, 1, 0, 1, 0, 1'b0, 1'b0);
    run_game(1'b0, 1'b0, 16'h0001, 0, 0, 0, 0, 1'b0, 1'b1);
    run_game(1'b0, 1'b0, 16'h0001, 0, 0, 0, 3, 1'b0, 1'b0);
    run_game(1'b1, 1'b0, 16'h0001, 0, 0, 0, 0, 1'b1, 1'b0);
    run_game(1'b0, 1'b0, 16'h0000, 0, 0, 0, 0, 1'b0, 1'b0);

    for (int g = 0; g < 14; g++) begin
      sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      fr = 0; fi = 0; fk = 0;
      if ($urandom_range(0, 3) != 0) begin
        fr = $urandom_range(1, DP);
        fi = $urandom_range(0, fr - 1);
        fk = $urandom_range(0, 2);
      end
      run_game(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sd,
               fr, fi, fk, 0, 1'b0, 1'b0);
    end

    repeat (5) tick();
    check("led_queue_drained", exp_leds.size(), 0);
    check("end_queue_drained", exp_fim.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/geogenius_seq_engine.md
Name: geogenius_seq_engine

Overview:
- Parametrised successor of the single-round memory game core: a Simon-style sequence engine.
- Per round it appends one pseudo-random button to a stored sequence, replays it on the LEDs, then collects and checks the player's presses.
- It adds a configurable button count and sequence depth, selectable progressive or fixed-replay mode, per-press timeout with two difficulty levels, and a play-time counter.
- It sits between the board buttons/LEDs and the score/time 7-segment decoders in the top level.

Parameters:
- N_BOTOES, 8: number of buttons/LEDs; power of two, 2..16. IDX_W = log2(N_BOTOES).
- DEPTH, 16: maximum sequence length, 2..32. SCORE_W = clog2(DEPTH+1).
- MOSTRA_CICLOS, 1000: cycles each LED is lit during replay; an equal dark gap follows each item.
- TIMEOUT_NORMAL, 5000: cycles allowed per press when dificuldade=0.
- TIMEOUT_DIFICIL, 2500: cycles allowed per press when dificuldade=1.
- PRESCALE, 1000: clock cycles per tempo_de_jogo tick.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- jogar  in  1  start pulse; acted on only in INICIAL or a FIM_* state.
- dificuldade  in  1  sampled on accepted jogar; 1 selects TIMEOUT_DIFICIL.
- modo  in  1  sampled on accepted jogar. 0 = replay the whole sequence each round. 1 = replay only the newest item.
- semente  in  16  LFSR seed, loaded on accepted jogar.
- botoes  in  N_BOTOES  raw button levels, already synchronised, one bit per button.
- leds  out  N_BOTOES  one-hot replay output; also echoes botoes while in ESPERA.
- pronto  out  1  high in all FIM_* states.
- acertou  out  1  high in FIM_ACERTO.
- errou  out  1  high in FIM_ERRO.
- timeout  out  1  high in FIM_TIMEOUT.
- score  out  SCORE_W  number of completed rounds.
- tempo_de_jogo  out  16  PRESCALE ticks elapsed since the accepted jogar; saturates at 16'hFFFF.
- db_estado  out  4  current state code.

Behaviour:
Reset (reset=0 at a clock edge):
- State goes to INICIAL; round/index counters, score, timers and tempo_de_jogo go to 0.
- LFSR goes to 16'hACE1; all outputs are 0.
- Reset applied mid-game aborts immediately; the stored sequence is don't-care.

LFSR:
- 16-bit Fibonacci, shift left, feedback b15^b13^b12^b10.
- Seed: semente, or 16'hACE1 if semente=0.
- Advances exactly once per GERA state.
- New item = LFSR[IDX_W-1:0] after the advance. Items are stored in a DEPTH x IDX_W register array at address rodada-1.

States and codes:
- INICIAL 0: accepted jogar goes to PREPARA.
- PREPARA 1: load seed; sample modo and dificuldade; rodada=0, score=0, tempo=0. Goes to GERA.
- GERA 2: rodada++ (rodada then counts 1..DEPTH); advance LFSR; write item. Goes to MOSTRA.
- MOSTRA 3: leds = one-hot of mem[i] for MOSTRA_CICLOS cycles.
  - Start index i is 0 when modo=0, or rodada-1 when modo=1.
  - Goes to INTERVALO.
- INTERVALO 4: leds=0 for MOSTRA_CICLOS cycles.
  - If i < rodada-1: i++ and return to MOSTRA.
  - Otherwise: i=0, clear timeout counter, go to ESPERA.
- ESPERA 5: waits for a press.
  - A press is a rising edge of |botoes, using a one-cycle registered copy.
  - On a press: register botoes, go to COMPARA.
  - If the timeout counter reaches the selected limit with no press: go to FIM_TIMEOUT.
  - A press and the limit in the same cycle: the press wins.
- COMPARA 6: the registered jogada must equal the one-hot of mem[i] exactly. Multiple bits set counts as wrong.
  - Wrong: go to FIM_ERRO.
  - Right and i < rodada-1: i++, clear timeout counter, go to ESPERA.
  - Right and last item: go to PROXIMA.
- PROXIMA 7: score = rodada.
  - If rodada == DEPTH: go to FIM_ACERTO.
  - Otherwise: i=0, go to GERA.
- FIM_ACERTO 8, FIM_ERRO 9, FIM_TIMEOUT 10: outputs held. Accepted jogar goes to PREPARA.

tempo_de_jogo:
- Counts in every state from PREPARA up to, but not including, FIM_*.
- Frozen in FIM_*; cleared in PREPARA.

Latency and hold rules:
- A press is seen in ESPERA one cycle after the edge; the compare result is available the following cycle.
- Buttons held across the COMPARA→ESPERA transition do not produce a second press; a release is required.
- jogar in any other state is ignored.

Decomposition:
- Package geogenius_pkg: state enum with the codes above, LFSR taps constant, default seed 16'hACE1.
- One sub-module, geogenius_lfsr16: load, advance, seed-zero substitution.

Test Plan:
Shared setup: N_BOTOES=4, DEPTH=3, MOSTRA_CICLOS=4, TIMEOUT_NORMAL=20, TIMEOUT_DIFICIL=10, PRESCALE=10, semente=16'h0001. The generated sequence is 2,0,0.
1. modo=0, correct presses throughout → leds show 0100; then 0100,0001; then 0100,0001,0001. Ends in FIM_ACERTO with acertou=1, pronto=1, score=3.
2. modo=1, same run → each replay shows only the newest item (0100, 0001, 0001). Ends in FIM_ACERTO, score=3.
3. Round 2, first press 0001 instead of 0100 → FIM_ERRO, errou=1, score=1, db_estado=9.
4. dificuldade=1, no press after the round-1 replay → timeout=1 exactly 10 cycles after entering ESPERA; score=0. With dificuldade=0 the same run times out after 20 cycles.
5. Press 0101 (two buttons) in round 1 → FIM_ERRO. In a separate run, holding the correct button through the next ESPERA yields no extra press.
6. reset=0 asserted mid-MOSTRA → next cycle INICIAL, leds=0, score=0, tempo_de_jogo=0. jogar pulsed during ESPERA is ignored.
